// File: rtl/csa_pkg.sv
// Shared parameters and helpers for the pipelined carry-select adder.
package csa_pkg;

  localparam logic SEL_C0 = 1'b0;
  localparam logic SEL_C1 = 1'b1;

  function automatic int slice_w(
    input int width,
    input int stages
  );
    return (stages >= 1) ? width / stages : width;
  endfunction

  function automatic bit cfg_ok(
    input int width,
    input int stages
  );
    return (stages >= 1) && (stages <= width) &&
           (width % stages == 0);
  endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// Operand and result valid/ready handshakes of csa_pipe_adder.
interface csa_pipe_adder_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/csa_slice.sv
// One carry-select slice: two adders for carry-in 0/1, then a select.
module csa_slice
  import csa_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          c_in,
  output logic [SW-1:0] s,
  output logic          c_out
);

  logic [SW:0] r0;
  logic [SW:0] r1;

  assign r0 = {1'b0, a} + {1'b0, b};
  assign r1 = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, 1'b1};

  always_comb begin
    {c_out, s} = r0;
    unique case (c_in)
      SEL_C0:  {c_out, s} = r0;
      SEL_C1:  {c_out, s} = r1;
      default: {c_out, s} = r0;
    endcase
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor, one slice per stage,
// operands skewed in and results de-skewed out on a rigid pipeline.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic             clk,
  input logic             rst,
  csa_pipe_adder_if.slave bus
);

  localparam int SW = slice_w(WIDTH, STAGES);
  localparam int L  = STAGES - 1;

  logic             adv;
  logic             acc;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             ovf_nx;
  logic             ovf_q;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("csa_pipe_adder: bad WIDTH/STAGES");
  end

  assign adv          = !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && adv;
  assign bus.in_ready = adv;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  assign c_eff        = bus.cin ^ bus.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // a_in/b_in hold the not-yet-added operand bits, current slice lowest
    localparam int RW = WIDTH - k * SW;

    logic [RW-1:0]         a_in;
    logic [RW-1:0]         b_in;
    logic                  c_in;
    logic                  v_in;
    logic [SW-1:0]         ss;
    logic                  sc;
    logic [(k+1)*SW-1:0]   r_nx;
    logic [(k+1)*SW-1:0]   r_q;
    logic                  v_q;
    logic                  c_q;

    if (k == 0) begin : g_head
      assign a_in = bus.a;
      assign b_in = b_eff;
      assign c_in = c_eff;
      assign v_in = acc;
      assign r_nx = ss;
    end else begin : g_body
      assign a_in = g_st[k-1].g_skew.a_q;
      assign b_in = g_st[k-1].g_skew.b_q;
      assign c_in = g_st[k-1].c_q;
      assign v_in = g_st[k-1].v_q;
      assign r_nx = {ss, g_st[k-1].r_q};
    end

    csa_slice #(
      .SW (SW)
    ) u_slice (
      .a     (a_in[SW-1:0]),
      .b     (b_in[SW-1:0]),
      .c_in  (c_in),
      .s     (ss),
      .c_out (sc)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= sc;
        r_q <= r_nx;
      end
    end

    if (k < L) begin : g_skew
      logic [RW-SW-1:0] a_q;
      logic [RW-SW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[RW-1:SW];
          b_q <= b_in[RW-1:SW];
        end
      end
    end
  end

  assign ovf_nx =
    (g_st[L].a_in[SW-1] == g_st[L].b_in[SW-1]) &&
    (g_st[L].ss[SW-1] != g_st[L].a_in[SW-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_nx;
    end
  end

  assign bus.out_valid = g_st[L].v_q;
  assign bus.sum       = g_st[L].r_q;
  assign bus.cout      = g_st[L].c_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboarded bench for csa_pipe_adder in three WIDTH/STAGES setups.
module tb_csa_pipe_adder;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  csa_pipe_adder_if #(.WIDTH(32)) i0 ();
  csa_pipe_adder_if #(.WIDTH(32)) i1 ();
  csa_pipe_adder_if #(.WIDTH(64)) i2 ();

  csa_pipe_adder #(.WIDTH(32), .STAGES(4)) u0 (
    .clk (clk), .rst (rst), .bus (i0)
  );
  csa_pipe_adder #(.WIDTH(32), .STAGES(1)) u1 (
    .clk (clk), .rst (rst), .bus (i1)
  );
  csa_pipe_adder #(.WIDTH(64), .STAGES(8)) u2 (
    .clk (clk), .rst (rst), .bus (i2)
  );

  int checks = 0;
  int errors = 0;
  int nprint = 0;
  bit stop = 1'b0;
  int acc0 = 0, acc1 = 0, acc2 = 0;
  int con0 = 0, con1 = 0, con2 = 0;
  beat_t q0[$], q1[$], q2[$];
  beat_t e0, e1, e2;

  function automatic beat_t mk(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        cin,
    input logic        sub,
    input int          w
  );
    beat_t r;
    logic [63:0] m, aa, bb;
    logic [64:0] f;
    m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    aa = a & m;
    bb = (sub ? ~b : b) & m;
    f  = {1'b0, aa} + {1'b0, bb} + {64'd0, cin ^ sub};
    r.a    = aa;
    r.b    = b & m;
    r.cin  = cin;
    r.sub  = sub;
    r.sum  = f[63:0] & m;
    r.cout = f[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(7))
      0: r = 64'h0;
      1: r = {64{1'b1}};
      2: r = 64'h8000_0000_8000_0000;
      3: r = 64'h7FFF_FFFF_7FFF_FFFF;
      default: ;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
    end else begin
      if (i0.in_valid && i0.in_ready) begin
        q0.push_back(mk({32'd0, i0.a}, {32'd0, i0.b},
                        i0.cin, i0.sub, 32));
        acc0++;
      end
      if (i0.out_valid && i0.out_ready) begin
        con0++;
        checks++;
        if (q0.size() == 0) begin
          errors++;
          stop = 1'b1;
          if (nprint++ < 20)
            $display("FAIL sb0_extra: got sum=%h, required no result",
                     i0.sum);
        end else begin
          e0 = q0.pop_front();
          if ({i0.cout, i0.ovf, i0.sum} !==
              {e0.cout, e0.ovf, e0.sum[31:0]}) begin
            errors++;
            stop = 1'b1;
            if (nprint++ < 20)
              $display({"FAIL sb0 a=%h b=%h cin=%b sub=%b ",
                        "required sum=%h cout=%b ovf=%b ",
                        "got sum=%h cout=%b ovf=%b"},
                       e0.a[31:0], e0.b[31:0], e0.cin, e0.sub,
                       e0.sum[31:0], e0.cout, e0.ovf,
                       i0.sum, i0.cout, i0.ovf);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      if (i1.in_valid && i1.in_ready) begin
        q1.push_back(mk({32'd0, i1.a}, {32'd0, i1.b},
                        i1.cin, i1.sub, 32));
        acc1++;
      end
      if (i1.out_valid && i1.out_ready) begin
        con1++;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          stop = 1'b1;
          if (nprint++ < 20)
            $display("FAIL sb1_extra: got sum=%h, required no result",
                     i1.sum);
        end else begin
          e1 = q1.pop_front();
          if ({i1.cout, i1.ovf, i1.sum} !==
              {e1.cout, e1.ovf, e1.sum[31:0]}) begin
            errors++;
            stop = 1'b1;
            if (nprint++ < 20)
              $display({"FAIL sb1 a=%h b=%h cin=%b sub=%b ",
                        "required sum=%h cout=%b ovf=%b ",
                        "got sum=%h cout=%b ovf=%b"},
                       e1.a[31:0], e1.b[31:0], e1.cin, e1.sub,
                       e1.sum[31:0], e1.cout, e1.ovf,
                       i1.sum, i1.cout, i1.ovf);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
    end else begin
      if (i2.in_valid && i2.in_ready) begin
        q2.push_back(mk(i2.a, i2.b, i2.cin, i2.sub, 64));
        acc2++;
      end
      if (i2.out_valid && i2.out_ready) begin
        con2++;
        checks++;
        if (q2.size() == 0) begin
          errors++;
          stop = 1'b1;
          if (nprint++ < 20)
            $display("FAIL sb2_extra: got sum=%h, required no result",
                     i2.sum);
        end else begin
          e2 = q2.pop_front();
          if ({i2.cout, i2.ovf, i2.sum} !==
              {e2.cout, e2.ovf, e2.sum}) begin
            errors++;
            stop = 1'b1;
            if (nprint++ < 20)
              $display({"FAIL sb2 a=%h b=%h cin=%b sub=%b ",
                        "required sum=%h cout=%b ovf=%b ",
                        "got sum=%h cout=%b ovf=%b"},
                       e2.a, e2.b, e2.cin, e2.sub,
                       e2.sum, e2.cout, e2.ovf,
                       i2.sum, i2.cout, i2.ovf);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put0(
    input logic        v,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        cin,
    input logic        sub
  );
    i0.in_valid = v;
    i0.a        = a;
    i0.b        = b;
    i0.cin      = cin;
    i0.sub      = sub;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    put0(1'b1, 32'h1234_5678, 32'h10, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({i0.out_valid, i0.cout, i0.ovf, i0.sum, i0.in_ready} !==
          {3'b000, 32'd0, 1'b1}) begin
        errors++;
        $display({"FAIL reset_state c%0d: got v=%b cout=%b ovf=%b ",
                  "sum=%h rdy=%b, required 0 0 0 0 1"},
                 c, i0.out_valid, i0.cout, i0.ovf, i0.sum,
                 i0.in_ready);
      end
    end
    tick();
    rst = 1'b0;
    i0.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (i0.in_ready !== 1'b1 || i0.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b v=%b, required 1 0",
               i0.in_ready, i0.out_valid);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (i0.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_accept: got %0d results, required 0",
               seen);
    end
  endtask

  task automatic test_ripple();
    int n;
    tick();
    put0(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (i0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ripple_ready: got %b, required 1", i0.in_ready);
    end
    tick();
    i0.in_valid = 1'b0;
    n = 0;
    for (int c = 1; c <= 12 && n == 0; c++) begin
      @(negedge clk);
      if (i0.out_valid) n = c;
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL ripple_latency: got %0d cycles, required 4", n);
    end
    checks++;
    if ({i0.sum, i0.cout, i0.ovf} !== {32'h0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ripple_result: got %h/%b/%b, required 0/1/0",
               i0.sum, i0.cout, i0.ovf);
    end
  endtask

  task automatic test_sub();
    int n;
    tick();
    put0(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
    tick();
    put0(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
    tick();
    i0.in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 12 && n == 0; c++) begin
      @(negedge clk);
      if (i0.out_valid) n = c + 1;
    end
    checks++;
    if (n == 0 ||
        {i0.sum, i0.cout, i0.ovf} !== {32'hFFFF_FFFE, 2'b00}) begin
      errors++;
      $display("FAIL sub_5_7: got %h/%b/%b v=%b, required fffffffe/0/0",
               i0.sum, i0.cout, i0.ovf, i0.out_valid);
    end
    @(negedge clk);
    checks++;
    if (i0.out_valid !== 1'b1 ||
        {i0.sum, i0.cout, i0.ovf} !== {32'h7FFF_FFFF, 2'b11}) begin
      errors++;
      $display("FAIL sub_ovf: got %h/%b/%b v=%b, required 7fffffff/1/1",
               i0.sum, i0.cout, i0.ovf, i0.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int idx, c, c0;
    idx = 0;
    c = 0;
    c0 = con0;
    while ((idx < 10 || con0 - c0 < 10) && c < 60) begin
      tick();
      i0.out_ready = !(c >= 3 && c <= 5);
      if (idx < 10)
        put0(1'b1, 32'(idx), 32'(idx) << 8, 1'b0, 1'b0);
      else
        i0.in_valid = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if (i0.in_ready !== 1'b1 || i0.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_pre: got rdy=%b v=%b, required 1 0",
                   i0.in_ready, i0.out_valid);
        end
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (i0.in_ready !== 1'b0 || i0.out_valid !== 1'b1 ||
            {i0.sum, i0.cout, i0.ovf} !== 34'd0) begin
          errors++;
          $display({"FAIL bp_stall c%0d: got rdy=%b v=%b sum=%h, ",
                    "required 0 1 00000000"},
                   c, i0.in_ready, i0.out_valid, i0.sum);
        end
      end
      if (c == 7) begin
        checks++;
        if (i0.out_valid !== 1'b1 || i0.sum !== 32'd257) begin
          errors++;
          $display("FAIL bp_next: got v=%b sum=%h, required 1 00000101",
                   i0.out_valid, i0.sum);
        end
      end
      if (i0.in_valid && i0.in_ready) idx++;
      c++;
    end
    i0.in_valid  = 1'b0;
    i0.out_ready = 1'b1;
    checks++;
    if (idx != 10 || con0 - c0 != 10) begin
      errors++;
      $display("FAIL bp_count: got %0d in %0d out, required 10 10",
               idx, con0 - c0);
    end
  endtask

  task automatic test_reset_mid();
    int seen, n;
    for (int c = 0; c < 3; c++) begin
      tick();
      put0(1'b1, 32'h100 + 32'(c), 32'h7, 1'b0, 1'b0);
    end
    tick();
    rst = 1'b1;
    put0(1'b1, 32'hDEAD, 32'h1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    i0.in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (i0.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_flush: got %0d results, required 0", seen);
    end
    tick();
    put0(1'b1, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0);
    tick();
    i0.in_valid = 1'b0;
    n = 0;
    for (int c = 1; c <= 12 && n == 0; c++) begin
      @(negedge clk);
      if (i0.out_valid) n = c;
    end
    checks++;
    if (n != 4 || i0.sum !== 32'h0002_0000 || i0.cout !== 1'b0) begin
      errors++;
      $display({"FAIL rstmid_next: got lat=%0d sum=%h cout=%b, ",
                "required 4 00020000 0"}, n, i0.sum, i0.cout);
    end
  endtask

  task automatic test_random();
    int base, c;
    logic [63:0] x;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    base = acc0 + acc1 + acc2;
    c = 0;
    while (!stop && acc0 + acc1 + acc2 - base < 10000 && c < 40000) begin
      tick();
      x = pick();
      i0.in_valid  = ($urandom_range(3) != 0);
      i0.a         = x[31:0];
      x = pick();
      i0.b         = x[31:0];
      i0.cin       = 1'($urandom_range(1));
      i0.sub       = 1'($urandom_range(1));
      i0.out_ready = 1'($urandom_range(1));
      x = pick();
      i1.in_valid  = ($urandom_range(3) != 0);
      i1.a         = x[31:0];
      x = pick();
      i1.b         = x[31:0];
      i1.cin       = 1'($urandom_range(1));
      i1.sub       = 1'($urandom_range(1));
      i1.out_ready = 1'($urandom_range(1));
      i2.in_valid  = ($urandom_range(3) != 0);
      i2.a         = pick();
      i2.b         = pick();
      i2.cin       = 1'($urandom_range(1));
      i2.sub       = 1'($urandom_range(1));
      i2.out_ready = 1'($urandom_range(1));
      c++;
    end
    checks++;
    if (!stop && acc0 + acc1 + acc2 - base < 10000) begin
      errors++;
      $display("FAIL random_budget: got %0d beats, required 10000",
               acc0 + acc1 + acc2 - base);
    end
    tick();
    i0.in_valid = 1'b0;
    i1.in_valid = 1'b0;
    i2.in_valid = 1'b0;
    i0.out_ready = 1'b1;
    i1.out_ready = 1'b1;
    i2.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d/%0d/%0d pending, required 0",
               q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    void'($urandom(32'hC5A1_0001));
    i0.in_valid = 1'b0; i0.a = '0; i0.b = '0;
    i0.cin = 1'b0; i0.sub = 1'b0; i0.out_ready = 1'b1;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0;
    i1.cin = 1'b0; i1.sub = 1'b0; i1.out_ready = 1'b1;
    i2.in_valid = 1'b0; i2.a = '0; i2.b = '0;
    i2.cin = 1'b0; i2.sub = 1'b0; i2.out_ready = 1'b1;
    test_reset();
    test_ripple();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor for the arithmetic-circuit library. It is the sequential successor to the fixed 32-bit carry-select adder. It splits a WIDTH-bit operation into STAGES slices and computes one slice per pipeline stage, passing the carry between stages. Operands stream through a valid/ready handshake, with full-throughput back-pressure. Results are bit-exact against the behavioural sum.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and slice count; 1..WIDTH. Slice width SW = WIDTH/STAGES.
- clk  input  1  rising-edge clock.
- rst  input  1  reset. One clock domain. Reset is synchronous and active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0: A+B+cin; 1: A+~B+(~cin).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out. For subtraction: 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.

## Operation
- Effective operand: b_eff = sub ? ~b : b. Effective carry: c_eff = cin ^ sub.
  - sub=1, cin=0 gives A−B.
  - sub=1, cin=1 gives A−B−1.
- Required result: {cout,sum} = a + b_eff + c_eff, taken modulo 2^(WIDTH+1).
- ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]).
- Stage k (0..STAGES-1) handles bits [k*SW +: SW]:
  - It precomputes sum0/sum1 and c0/c1 for carry-in 0 and 1.
  - It selects both with the carry registered from stage k-1; stage 0 uses c_eff.
  - The result is registered together with the carry-out.
- Operand slices above stage k travel in skew registers until they reach their stage.
- Finished low slices travel in de-skew registers, so that all sum bits leave together.
- Each stage carries a valid bit. The pipeline is a rigid shift register with one global enable.
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
- When adv=1, every stage shifts.
  - The stage-0 valid bit loads in_valid && in_ready.
  - Bubbles propagate as valid=0.
- When adv=0, all stage registers, including the valid bits and sum/cout/ovf, hold.
- No reordering, no loss, and no duplication of beats.

## Timing
- Latency is exactly STAGES cycles from acceptance to out_valid, provided there are no stalls.
- Each stall cycle (out_valid && !out_ready) adds one cycle.
- Throughput is one beat per cycle while out_ready=1.
- out_valid, sum, cout and ovf are registered outputs.
  - They are stable while out_valid && !out_ready.
- in_ready is combinational from out_valid/out_ready. It has no path from in_valid.
- Reset values: all stage valid bits 0, out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 during reset and on the cycle after.
- Reset asserted mid-stream discards all in-flight beats on that edge.
  - No partial result is emitted afterwards.
  - Beats presented while rst=1 are not accepted.
- STAGES=1: a single carry-select stage, registered. Latency 1.
- Simultaneous input accept and output consume in the same cycle are both legal at full rate.

## Structure
- Package csa_pkg:
  - Function slice_w(WIDTH,STAGES).
  - Elaboration-time check that WIDTH%STAGES==0 and STAGES>=1.
  - Localparam conventions for the carry-select mux.
- Sub-module csa_slice:
  - Purely combinational, parameter SW.
  - Inputs: a, b, c_in. Outputs: s, c_out.
  - Internally uses dual ripple adders plus select.
  - Instanced once per stage via generate.
- The top level owns the skew/de-skew registers, valid chain, stall logic and ovf.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0, no beat accepted.
- Full carry ripple: WIDTH=32, STAGES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0.
  - Expect out_valid exactly 4 cycles after acceptance, sum=0x00000000, cout=1, ovf=0.
- Subtract:
  - a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Back-pressure: stream 10 beats (a=i, b=i<<8) with out_ready=0 on cycles 3–5.
  - Expect in_ready=0 during the stall and outputs held stable.
  - All 10 results arrive in order, none dropped or duplicated.
- Reset mid-stream: assert rst with 3 beats in flight → no out_valid for those beats.
  - The next accepted beat emits after exactly STAGES cycles.
- Random: 10000 vectors with seeded random a, b, cin, sub and random out_ready.
  - Compare against the behavioural model for {WIDTH,STAGES} = {32,4}, {32,1}, {64,8}.
  - On the first mismatch, print a, b, cin, sub, the expected value and the actual value, then stop.
